// File: rtl/tensor_loader.sv
// tensor_loader: ROWS x COLS parameter store for RNN weight/bias tensors.
//
// Two write paths share param_in:
//   - addressed write (write, sel_r, sel_c), honoured only while idle;
//   - streaming burst (start, in_valid/in_ready), written in raster order.
// One registered read port (rd_r, rd_c -> param_out) with 1-cycle latency.
//
// Ports:
//   clk        sole clock, posedge
//   reset      synchronous active-high reset
//   write      addressed write strobe
//   sel_r/c    addressed write row/column select
//   param_in   write data for both write paths
//   start      one-cycle pulse starting a burst load
//   in_valid   burst element valid
//   in_ready   loader accepts a burst element
//   rd_r/c     read row/column select
//   param_out  registered read data (0 for out-of-range selects)
//   busy       burst in progress
//   done       one-cycle pulse after the last burst element is written
//
// Optional feature, enabled by defining TENSOR_LOADER_ROWOUT_EN:
//   row_out    registered copy of the whole row selected by rd_r,
//              column c at bits [c*DATA_W +: DATA_W].

module tensor_loader #(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 16,
  parameter int unsigned DATA_W = 16,
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [RW-1:0]     sel_r,
  input  logic [CW-1:0]     sel_c,
  input  logic [DATA_W-1:0] param_in,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RW-1:0]     rd_r,
  input  logic [CW-1:0]     rd_c,
  output logic [DATA_W-1:0] param_out,
  output logic              busy,
  output logic              done
`ifdef TENSOR_LOADER_ROWOUT_EN
  ,
  output logic [COLS*DATA_W-1:0] row_out
`endif
);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  localparam logic [RW-1:0] LastRow = RW'(ROWS - 1);
  localparam logic [CW-1:0] LastCol = CW'(COLS - 1);

  state_e              state_q;
  logic [RW-1:0]       cnt_r_q;
  logic [CW-1:0]       cnt_c_q;
  logic [DATA_W-1:0]   mem_q [ROWS][COLS];

  logic                addr_we;
  logic                strm_we;
  logic [DATA_W-1:0]   rd_word;

  // Addressed writes only land while idle; the stream owns the array otherwise.
  assign addr_we = (state_q == StIdle) && write;
  assign strm_we = (state_q == StStream) && in_valid;

  // Handshake/status outputs decode the state register directly.
  assign busy     = (state_q == StStream);
  assign in_ready = (state_q == StStream);
  assign done     = (state_q == StDone);

  // Burst sequencer: raster-order counters advance on each accepted element.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_r_q <= '0;
      cnt_c_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StStream;
            cnt_r_q <= '0;
            cnt_c_q <= '0;
          end
        end
        StStream: begin
          if (in_valid) begin
            if (cnt_c_q == LastCol) begin
              cnt_c_q <= '0;
              if (cnt_r_q == LastRow) begin
                cnt_r_q <= '0;
                state_q <= StDone;
              end else begin
                cnt_r_q <= cnt_r_q + RW'(1);
              end
            end else begin
              cnt_c_q <= cnt_c_q + CW'(1);
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage array. Decoding by equality against each index means an
  // out-of-range select simply matches no entry, so the write is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (addr_we && (sel_r == RW'(r)) && (sel_c == CW'(c))) begin
            mem_q[r][c] <= param_in;
          end else if (strm_we && (cnt_r_q == RW'(r)) && (cnt_c_q == CW'(c))) begin
            mem_q[r][c] <= param_in;
          end
        end
      end
    end
  end

  // Read mux: out-of-range selects fall through to zero. Reading the
  // pre-edge array gives read-before-write for a same-cycle hit.
  always_comb begin
    rd_word = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ((rd_r == RW'(r)) && (rd_c == CW'(c))) begin
          rd_word = mem_q[r][c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      param_out <= '0;
    end else begin
      param_out <= rd_word;
    end
  end

`ifdef TENSOR_LOADER_ROWOUT_EN
  logic [COLS*DATA_W-1:0] rd_row;

  always_comb begin
    rd_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rd_r == RW'(r)) begin
        for (int c = 0; c < COLS; c++) begin
          rd_row[c*DATA_W +: DATA_W] = mem_q[r][c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_out <= '0;
    end else begin
      row_out <= rd_row;
    end
  end
`endif

endmodule

// File: tb/tb_tensor_loader.sv
// Self-checking bench for tensor_loader: a 4x16 instance and a 3x5 instance
// share stimulus; a flat-array reference model tracks whichever one is
// selected by dsel. Burst elements land at index k of the raster order.

module tb_tensor_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, write, start, in_valid;
  logic [1:0]  sel_r, rd_r;
  logic [3:0]  sel_c, rd_c;
  logic [15:0] param_in;

  logic        b_in_ready, b_busy, b_done;
  logic [15:0] b_param_out;
  logic        s_in_ready, s_busy, s_done;
  logic [15:0] s_param_out;
`ifdef TENSOR_LOADER_ROWOUT_EN
  logic [255:0] b_row_out;
  logic [79:0]  s_row_out;
`endif

  tensor_loader #(.ROWS(4), .COLS(16), .DATA_W(16)) u_big (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .sel_r     (sel_r),
    .sel_c     (sel_c),
    .param_in  (param_in),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .rd_r      (rd_r),
    .rd_c      (rd_c),
    .param_out (b_param_out),
    .busy      (b_busy),
    .done      (b_done)
`ifdef TENSOR_LOADER_ROWOUT_EN
    ,
    .row_out   (b_row_out)
`endif
  );

  tensor_loader #(.ROWS(3), .COLS(5), .DATA_W(16)) u_small (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .sel_r     (sel_r),
    .sel_c     (sel_c[2:0]),
    .param_in  (param_in),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .rd_r      (rd_r),
    .rd_c      (rd_c[2:0]),
    .param_out (s_param_out),
    .busy      (s_busy),
    .done      (s_done)
`ifdef TENSOR_LOADER_ROWOUT_EN
    ,
    .row_out   (s_row_out)
`endif
  );

  // Reference model
  int          dsel, mr, mc;
  int          m_phase;   // 0 idle, 1 loading, 2 finished pulse
  int          m_k;       // elements accepted in current burst
  logic [15:0] m_mem [64];
  logic [15:0] m_out;

  int n_checks, n_errors, done_seen, acc_seen;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: advance the model from the applied inputs, clock, compare.
  task automatic step();
    int er, ec, wr, wc;
    logic [255:0] row_exp;
    logic g_busy, g_rdy, g_done;
    logic [15:0] g_out;
    er = int'(rd_r);
    ec = dsel ? int'(rd_c[2:0]) : int'(rd_c);
    wr = int'(sel_r);
    wc = dsel ? int'(sel_c[2:0]) : int'(sel_c);
    row_exp = '0;
    g_rdy = dsel ? s_in_ready : b_in_ready;
    if (!reset && g_rdy && in_valid) acc_seen++;
    if (reset) begin
      for (int i = 0; i < 64; i++) m_mem[i] = '0;
      m_phase = 0;
      m_k = 0;
      m_out = '0;
    end else begin
      m_out = (er < mr && ec < mc) ? m_mem[er*mc + ec] : 16'h0;
      if (er < mr) begin
        for (int c = 0; c < mc; c++) row_exp[c*16 +: 16] = m_mem[er*mc + c];
      end
      case (m_phase)
        0: begin
          if (write && wr < mr && wc < mc) m_mem[wr*mc + wc] = param_in;
          if (start) begin
            m_phase = 1;
            m_k = 0;
          end
        end
        1: begin
          if (in_valid) begin
            m_mem[m_k] = param_in;
            m_k++;
            if (m_k == mr*mc) m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
    @(posedge clk);
    #1;
    g_busy = dsel ? s_busy : b_busy;
    g_rdy  = dsel ? s_in_ready : b_in_ready;
    g_done = dsel ? s_done : b_done;
    g_out  = dsel ? s_param_out : b_param_out;
    if (g_done === 1'b1) done_seen++;
    check("busy", g_busy, m_phase == 1);
    check("in_ready", g_rdy, m_phase == 1);
    check("done", g_done, m_phase == 2);
    check("param_out", g_out, m_out);
`ifdef TENSOR_LOADER_ROWOUT_EN
    check("row_out", dsel ? {176'b0, s_row_out} : b_row_out, row_exp);
`endif
  endtask

  // mode 0: continuous valid, 1: valid toggling, 2: random valid and data.
  // inj: on an idle-valid cycle mid-burst, raise write (0,0)=BEEF and start.
  task automatic burst(input int mode, input int base, input bit inj, output int cycles);
    int guard;
    guard = 0;
    done_seen = 0;
    acc_seen = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (m_phase == 1 && guard < 1000) begin
      case (mode)
        0: in_valid = 1'b1;
        1: in_valid = (guard % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      param_in = (mode == 2) ? 16'($urandom) : 16'(base + m_k);
      if (inj && guard == 3) begin
        in_valid = 1'b0;
        write = 1'b1;
        sel_r = 2'd0;
        sel_c = 4'd0;
        param_in = 16'hBEEF;
        start = 1'b1;
      end
      step();
      write = 1'b0;
      start = 1'b0;
      guard++;
    end
    in_valid = 1'b0;
    cycles = guard;
    if (guard >= 1000) check("burst_timeout", 1, 0);
    step();
    check("done_pulses", done_seen, 1);
    check("accepted", acc_seen, mr*mc);
  endtask

  task automatic read_all(input int rmax, input int cmax);
    for (int r = 0; r < rmax; r++) begin
      for (int c = 0; c < cmax; c++) begin
        rd_r = 2'(r);
        rd_c = 4'(c);
        step();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    n_checks = 0;
    n_errors = 0;
    dsel = 0;
    mr = 4;
    mc = 16;
    reset = 1'b1;
    write = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    sel_r = '0;
    sel_c = '0;
    rd_r = '0;
    rd_c = '0;
    param_in = '0;
    step();
    step();
    reset = 1'b0;

    // Addressed write and readback
    write = 1'b1; sel_r = 2'd1; sel_c = 4'd3; param_in = 16'hDEAD;
    step();
    write = 1'b0;
    rd_r = 2'd1; rd_c = 4'd3;
    step();
    check("t1_dead", b_param_out, 16'hDEAD);
    rd_r = 2'd0; rd_c = 4'd0;
    step();
    check("t1_zero", b_param_out, 16'h0);

    // Same-cycle read of the written entry returns the old value
    write = 1'b1; sel_r = 2'd2; sel_c = 4'd5; param_in = 16'h1234;
    rd_r = 2'd2; rd_c = 4'd5;
    step();
    check("rbw_old", b_param_out, 16'h0);
    write = 1'b0;
    step();
    check("rbw_new", b_param_out, 16'h1234);

    // Random addressed traffic
    repeat (60) begin
      write = 1'($urandom_range(0, 1));
      sel_r = 2'($urandom); sel_c = 4'($urandom);
      rd_r = 2'($urandom); rd_c = 4'($urandom);
      param_in = 16'($urandom);
      step();
    end
    write = 1'b0;

    // Continuous burst of 0..63
    burst(0, 0, 1'b0, cyc);
    check("t2_cycles", cyc, 64);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 16; c++) begin
        rd_r = 2'(r); rd_c = 4'(c);
        step();
        check("t2_pattern", b_param_out, 16'(r*16 + c));
      end
    end

    // Toggling valid
    burst(1, 100, 1'b0, cyc);
    check("t3_cycles", cyc, 127);
    read_all(4, 16);

    // Write and start during a burst are ignored
    burst(0, 16'h0200, 1'b1, cyc);
    check("t4_cycles", cyc, 65);
    rd_r = 2'd0; rd_c = 4'd0;
    step();
    check("t4_first", b_param_out, 16'h0200);

    // Reset mid-burst
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      param_in = 16'(16'h0300 + i);
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_busy", b_busy, 1'b0);
    check("t5_ready", b_in_ready, 1'b0);
    check("t5_done", b_done, 1'b0);
    read_all(4, 16);
    rd_r = 2'd0; rd_c = 4'd3;
    step();
    check("t5_cleared", b_param_out, 16'h0);
    burst(0, 16'h0400, 1'b0, cyc);
    read_all(4, 16);

    // Random bursts
    repeat (2) begin
      burst(2, 0, 1'b0, cyc);
      read_all(4, 16);
    end

    // 3x5 instance
    dsel = 1;
    mr = 3;
    mc = 5;
    reset = 1'b1;
    step();
    reset = 1'b0;
    write = 1'b1; sel_r = 2'd3; sel_c = 4'd0; param_in = 16'h5555;
    step();
    sel_r = 2'd0; sel_c = 4'd6; param_in = 16'h6666;
    step();
    sel_r = 2'd2; sel_c = 4'd4; param_in = 16'h7777;
    step();
    write = 1'b0;
    read_all(4, 8);
    rd_r = 2'd0; rd_c = 4'd6;
    step();
    check("t6_oor_col", s_param_out, 16'h0);
    rd_r = 2'd2; rd_c = 4'd4;
    step();
    check("t6_inrange", s_param_out, 16'h7777);
    burst(0, 16'h0900, 1'b0, cyc);
    check("t6_cycles", cyc, 15);
    read_all(4, 8);
    rd_r = 2'd2; rd_c = 4'd4;
    step();
    check("t6_last", s_param_out, 16'h090E);
    burst(2, 0, 1'b0, cyc);
    read_all(3, 5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
